smi_stream_bridge: RTL and testbench



---
 rtl/smi_stream_pkg.sv | 63 ++++++
 rtl/smi_stream_bridge_strobe_sync.sv | 40 ++++
 rtl/smi_stream_bridge.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_smi_stream_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_stream_pkg.sv
// Shared definitions for the SMI stream bridge: register map, status layout,
// framer state encoding, framed-TX header payload and counter helpers.
package smi_stream_pkg;

    localparam logic [7:0] SMI_VERSION_DEFAULT = 8'h02;

    // Register addresses on the IOC fabric
    localparam logic [4:0] REG_VERSION = 5'd0;
    localparam logic [4:0] REG_STATUS  = 5'd1;
    localparam logic [4:0] REG_CHANNEL = 5'd2;
    localparam logic [4:0] REG_DIR     = 5'd3;
    localparam logic [4:0] REG_MODE    = 5'd4;
    localparam logic [4:0] REG_UDF_CNT = 5'd5;
    localparam logic [4:0] REG_OVF_CNT = 5'd6;

    // Status register bit positions
    localparam int unsigned ST_RX_EMPTY = 0;
    localparam int unsigned ST_TX_FULL  = 1;
    localparam int unsigned ST_CH_LSB   = 2;
    localparam int unsigned ST_CH_W     = 3;
    localparam int unsigned ST_TEST     = 5;
    localparam int unsigned ST_MODE     = 6;
    localparam int unsigned ST_DIR      = 7;

    localparam int unsigned CNT_W         = 8;
    localparam logic [7:0]  TEST_CNT_INIT = 8'h56;
    localparam logic [31:0] FR_SYNC_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FR_SYNC = 2'd0,
        FR_B1   = 2'd1,
        FR_B2   = 2'd2,
        FR_B3   = 2'd3
    } fr_state_e;

    // Header byte of a framed TX word (bit 7 is the sync marker, not stored)
    typedef struct packed {
        logic       modem;
        logic       cond;
        logic [4:0] hdr;
    } fr_hdr_t;

    // Saturating counter step with read-clear; a same-cycle hit after clear yields 1
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] v,
                                                  input logic inc,
                                                  input logic clr);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : v;
        if (inc && (base != {CNT_W{1'b1}})) begin
            return base + CNT_W'(1);
        end
        return base;
    endfunction

    // Rebuild a modem word from header plus three 7-bit payload bytes
    function automatic logic [31:0] fr_assemble(input fr_hdr_t h,
                                                input logic [6:0] p1,
                                                input logic [6:0] p2,
                                                input logic [6:0] p3);
        return {2'b10, h.hdr, p1, p2[6], h.modem, 2'b01, p2[5:0], p3, 1'b0};
    endfunction

endpackage

// File: rtl/smi_stream_bridge_strobe_sync.sv
// smi_strobe_sync: brings an asynchronous active-low SMI strobe into the
// i_sys_clk domain and emits a one-cycle pulse per falling edge.
//   i_sys_clk, i_rst_b : clock, async active-low reset
//   i_strobe_b         : raw strobe from the SMI pins
//   o_fall             : registered pulse, 3 cycles after the strobe falls
module smi_strobe_sync (
    input  logic i_sys_clk,
    input  logic i_rst_b,
    input  logic i_strobe_b,
    output logic o_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic fall_q;
    logic fall_d;

    // Falling edge on the synchronised strobe
    always_comb begin
        fall_d = prev_q & ~sync_q;
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= i_strobe_b;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fall_q <= fall_d;
        end
    end

    assign o_fall = fall_q;

endmodule

// File: rtl/smi_stream_bridge.sv
// smi_stream_bridge: SMI bus <-> modem sample FIFO bridge with an IOC register
// block, RX prefetch/slicing, raw or framed TX packing, error counters and a
// test-pattern source.
//   Register fabric : i_ioc, i_data_in, o_data_out, i_cs, i_fetch_cmd, i_load_cmd
//   RX FIFO         : o_rx_fifo_pull, i_rx_fifo_data, i_rx_fifo_empty
//   TX FIFO         : o_tx_fifo_push, o_tx_fifo_data, i_tx_fifo_full
//   SMI pins        : i_smi_soe, i_smi_swe, i_smi_data, o_smi_data,
//                     o_smi_read_req, o_smi_write_req, i_smi_test
//   Config outputs  : o_channel, o_dir, o_cond_tx
module smi_stream_bridge #(
    parameter int unsigned SMI_W   = 8,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned NUM_CH  = 2,
    parameter logic [7:0]  VERSION = smi_stream_pkg::SMI_VERSION_DEFAULT
) (
    input  logic                      i_sys_clk,
    input  logic                      i_rst_b,
    input  logic [4:0]                i_ioc,
    input  logic [7:0]                i_data_in,
    output logic [7:0]                o_data_out,
    input  logic                      i_cs,
    input  logic                      i_fetch_cmd,
    input  logic                      i_load_cmd,
    output logic                      o_rx_fifo_pull,
    input  logic [WORD_W-1:0]         i_rx_fifo_data,
    input  logic                      i_rx_fifo_empty,
    output logic                      o_tx_fifo_push,
    output logic [WORD_W-1:0]         o_tx_fifo_data,
    input  logic                      i_tx_fifo_full,
    input  logic                      i_smi_soe,
    input  logic                      i_smi_swe,
    input  logic [SMI_W-1:0]          i_smi_data,
    output logic [SMI_W-1:0]          o_smi_data,
    output logic                      o_smi_read_req,
    output logic                      o_smi_write_req,
    input  logic                      i_smi_test,
    output logic [$clog2(NUM_CH)-1:0] o_channel,
    output logic                      o_dir,
    output logic                      o_cond_tx
);

    import smi_stream_pkg::*;

    localparam int unsigned CH_W      = $clog2(NUM_CH);
    localparam int unsigned BEATS     = WORD_W / SMI_W;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam bit          FRAMED_OK = (SMI_W == 8);

    // Strobe detection
    logic soe_fall;
    logic swe_fall;

    smi_strobe_sync u_soe_sync (
        .i_sys_clk  (i_sys_clk),
        .i_rst_b    (i_rst_b),
        .i_strobe_b (i_smi_soe),
        .o_fall     (soe_fall)
    );

    smi_strobe_sync u_swe_sync (
        .i_sys_clk  (i_sys_clk),
        .i_rst_b    (i_rst_b),
        .i_strobe_b (i_smi_swe),
        .o_fall     (swe_fall)
    );

    // State
    logic                  live_q;
    logic [CH_W-1:0]       ch_q,       ch_d;
    logic                  dir_q,      dir_d;
    logic                  mode_q,     mode_d;
    logic [7:0]            data_out_q, data_out_d;
    logic [CNT_W-1:0]      udf_cnt_q,  udf_cnt_d;
    logic [CNT_W-1:0]      ovf_cnt_q,  ovf_cnt_d;

    logic [WORD_W-1:0]     pf_word_q,  pf_word_d;
    logic                  pf_valid_q, pf_valid_d;
    logic                  pull_q,     pull_d;
    logic                  load_q,     load_d;
    logic [BEAT_W-1:0]     rx_beat_q,  rx_beat_d;
    logic [SMI_W-1:0]      smi_dout_q, smi_dout_d;
    logic [7:0]            test_cnt_q, test_cnt_d;

    logic [BEAT_W-1:0]     tx_beat_q,  tx_beat_d;
    logic [WORD_W-1:0]     tx_word_q,  tx_word_d;
    logic                  push_q,     push_d;
    logic [WORD_W-1:0]     tx_data_q,  tx_data_d;
    logic                  cond_tx_q,  cond_tx_d;
    fr_state_e             fr_state_q, fr_state_d;
    fr_hdr_t               fr_hdr_q,   fr_hdr_d;
    logic [6:0]            fr_p1_q,    fr_p1_d;
    logic [6:0]            fr_p2_q,    fr_p2_d;

    // Combinational helpers
    logic                  cfg_change;
    logic                  udf_inc;
    logic                  udf_clr;
    logic                  ovf_clr;
    logic                  resync;
    logic                  push_req;
    logic [WORD_W-1:0]     push_word;
    logic [WORD_W-1:0]     tx_shift;
    logic [7:0]            status;
    logic [7:0]            smi_byte;
    logic                  framed_en;
    logic [BEATS-1:0][SMI_W-1:0] rx_slices;

    assign rx_slices = pf_word_q;
    assign smi_byte  = i_smi_data[7:0];
    assign framed_en = mode_q & FRAMED_OK;

    // Status snapshot for register 1
    always_comb begin
        status                           = '0;
        status[ST_RX_EMPTY]              = i_rx_fifo_empty;
        status[ST_TX_FULL]               = i_tx_fifo_full;
        status[ST_CH_LSB +: ST_CH_W]     = ST_CH_W'(ch_q);
        status[ST_TEST]                  = i_smi_test;
        status[ST_MODE]                  = mode_q;
        status[ST_DIR]                   = dir_q;
    end

    // Register block: writes, reads, read-clear requests, config-change detect
    always_comb begin
        ch_d       = ch_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        data_out_d = data_out_q;
        udf_clr    = 1'b0;
        ovf_clr    = 1'b0;
        cfg_change = 1'b0;

        if (i_cs && i_load_cmd) begin
            case (i_ioc)
                REG_CHANNEL: begin
                    if (i_data_in < 8'(NUM_CH)) begin
                        ch_d = CH_W'(i_data_in);
                    end
                end
                REG_DIR: begin
                    dir_d      = i_data_in[0];
                    cfg_change = (i_data_in[0] != dir_q);
                end
                REG_MODE: begin
                    mode_d     = i_data_in[0];
                    cfg_change = (i_data_in[0] != mode_q);
                end
                default: ;
            endcase
        end

        if (i_cs && i_fetch_cmd) begin
            case (i_ioc)
                REG_VERSION: data_out_d = VERSION;
                REG_STATUS:  data_out_d = status;
                REG_CHANNEL: data_out_d = 8'(ch_q);
                REG_DIR:     data_out_d = {7'd0, dir_q};
                REG_MODE:    data_out_d = {7'd0, mode_q};
                REG_UDF_CNT: begin
                    data_out_d = udf_cnt_q;
                    udf_clr    = 1'b1;
                end
                REG_OVF_CNT: begin
                    data_out_d = ovf_cnt_q;
                    ovf_clr    = 1'b1;
                end
                default:     data_out_d = 8'h00;
            endcase
        end
    end

    // RX path: prefetch one word, hand it out slice by slice on SOE
    always_comb begin
        pf_word_d  = pf_word_q;
        pf_valid_d = pf_valid_q;
        pull_d     = 1'b0;
        load_d     = pull_q;
        rx_beat_d  = rx_beat_q;
        smi_dout_d = smi_dout_q;
        test_cnt_d = test_cnt_q;
        udf_inc    = 1'b0;

        // FIFO data arrives the cycle after the pop
        if (load_q) begin
            pf_word_d  = i_rx_fifo_data;
            pf_valid_d = 1'b1;
        end

        // Only one fetch in flight at a time
        if (!pf_valid_q && !pull_q && !load_q && !i_rx_fifo_empty && !i_smi_test) begin
            pull_d = 1'b1;
        end

        if (soe_fall) begin
            if (i_smi_test) begin
                smi_dout_d = SMI_W'(test_cnt_q);
                test_cnt_d = test_cnt_q + 8'd1;
            end else if (pf_valid_q) begin
                smi_dout_d = rx_slices[rx_beat_q];
                if (rx_beat_q == BEAT_W'(BEATS - 1)) begin
                    rx_beat_d  = '0;
                    pf_valid_d = 1'b0;
                end else begin
                    rx_beat_d = rx_beat_q + BEAT_W'(1);
                end
            end else begin
                smi_dout_d = '0;
                udf_inc    = 1'b1;
            end
        end

        if (cfg_change) begin
            rx_beat_d = '0;
        end
    end

    // TX path: raw shift-in or 4-byte framer, then push or drop on full
    always_comb begin
        tx_beat_d  = tx_beat_q;
        tx_word_d  = tx_word_q;
        fr_state_d = fr_state_q;
        fr_hdr_d   = fr_hdr_q;
        fr_p1_d    = fr_p1_q;
        fr_p2_d    = fr_p2_q;
        cond_tx_d  = cond_tx_q;
        tx_data_d  = tx_data_q;
        push_d     = 1'b0;
        push_req   = 1'b0;
        push_word  = '0;
        resync     = 1'b0;
        tx_shift   = (tx_word_q >> SMI_W) | (WORD_W'(i_smi_data) << (WORD_W - SMI_W));

        if (swe_fall) begin
            if (framed_en) begin
                case (fr_state_q)
                    FR_SYNC: begin
                        if (smi_byte[7]) begin
                            fr_hdr_d   = fr_hdr_t'(smi_byte[6:0]);
                            fr_state_d = FR_B1;
                        end else begin
                            push_req  = 1'b1;
                            push_word = WORD_W'(FR_SYNC_WORD);
                        end
                    end
                    FR_B1: begin
                        if (smi_byte[7]) begin
                            resync     = 1'b1;
                            fr_state_d = FR_SYNC;
                        end else begin
                            fr_p1_d    = smi_byte[6:0];
                            fr_state_d = FR_B2;
                        end
                    end
                    FR_B2: begin
                        if (smi_byte[7]) begin
                            resync     = 1'b1;
                            fr_state_d = FR_SYNC;
                        end else begin
                            fr_p2_d    = smi_byte[6:0];
                            fr_state_d = FR_B3;
                        end
                    end
                    default: begin
                        fr_state_d = FR_SYNC;
                        if (smi_byte[7]) begin
                            resync = 1'b1;
                        end else begin
                            push_req  = 1'b1;
                            push_word = WORD_W'(fr_assemble(fr_hdr_q, fr_p1_q, fr_p2_q,
                                                            smi_byte[6:0]));
                            cond_tx_d = fr_hdr_q.cond;
                        end
                    end
                endcase
            end else begin
                tx_word_d = tx_shift;
                if (tx_beat_q == BEAT_W'(BEATS - 1)) begin
                    tx_beat_d = '0;
                    push_req  = 1'b1;
                    push_word = tx_shift;
                end else begin
                    tx_beat_d = tx_beat_q + BEAT_W'(1);
                end
            end
        end

        if (push_req && !i_tx_fifo_full) begin
            push_d    = 1'b1;
            tx_data_d = push_word;
        end

        if (cfg_change) begin
            tx_beat_d  = '0;
            fr_state_d = FR_SYNC;
        end
    end

    // Error counters: underflow, and overflow/resync share one counter
    always_comb begin
        udf_cnt_d = cnt_next(udf_cnt_q, udf_inc, udf_clr);
        ovf_cnt_d = cnt_next(ovf_cnt_q, resync | (push_req & i_tx_fifo_full), ovf_clr);
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            live_q     <= 1'b0;
            ch_q       <= '0;
            dir_q      <= 1'b0;
            mode_q     <= 1'b0;
            data_out_q <= '0;
            udf_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
            pf_word_q  <= '0;
            pf_valid_q <= 1'b0;
            pull_q     <= 1'b0;
            load_q     <= 1'b0;
            rx_beat_q  <= '0;
            smi_dout_q <= '0;
            test_cnt_q <= TEST_CNT_INIT;
            tx_beat_q  <= '0;
            tx_word_q  <= '0;
            push_q     <= 1'b0;
            tx_data_q  <= '0;
            cond_tx_q  <= 1'b0;
            fr_state_q <= FR_SYNC;
            fr_hdr_q   <= '0;
            fr_p1_q    <= '0;
            fr_p2_q    <= '0;
        end else begin
            live_q     <= 1'b1;
            ch_q       <= ch_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            data_out_q <= data_out_d;
            udf_cnt_q  <= udf_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
            pf_word_q  <= pf_word_d;
            pf_valid_q <= pf_valid_d;
            pull_q     <= pull_d;
            load_q     <= load_d;
            rx_beat_q  <= rx_beat_d;
            smi_dout_q <= smi_dout_d;
            test_cnt_q <= test_cnt_d;
            tx_beat_q  <= tx_beat_d;
            tx_word_q  <= tx_word_d;
            push_q     <= push_d;
            tx_data_q  <= tx_data_d;
            cond_tx_q  <= cond_tx_d;
            fr_state_q <= fr_state_d;
            fr_hdr_q   <= fr_hdr_d;
            fr_p1_q    <= fr_p1_d;
            fr_p2_q    <= fr_p2_d;
        end
    end

    assign o_data_out     = data_out_q;
    assign o_rx_fifo_pull = pull_q;
    assign o_tx_fifo_push = push_q;
    assign o_tx_fifo_data = tx_data_q;
    assign o_smi_data     = smi_dout_q;
    assign o_channel      = ch_q;
    assign o_dir          = dir_q;
    assign o_cond_tx      = cond_tx_q;

    // Request lines follow the FIFO flags live; live_q pins them to their idle
    // values while in reset
    assign o_smi_read_req  = i_smi_test | (live_q & (pf_valid_q | ~i_rx_fifo_empty));
    assign o_smi_write_req = ~live_q | ~i_tx_fifo_full;

endmodule

// File: tb/tb_smi_stream_bridge.sv
// Directed bench for smi_stream_bridge (SMI_W=8, WORD_W=32, NUM_CH=2).
module tb_smi_stream_bridge;

    localparam int unsigned CH_W = $clog2(2);

    logic            clk;
    logic            rst_b;
    logic [4:0]      ioc;
    logic [7:0]      data_in;
    logic [7:0]      data_out;
    logic            cs;
    logic            fetch;
    logic            load;
    logic            rx_pull;
    logic [31:0]     rx_data;
    logic            rx_empty;
    logic            tx_push;
    logic [31:0]     tx_data;
    logic            tx_full;
    logic            soe;
    logic            swe;
    logic [7:0]      smi_wdata;
    logic [7:0]      smi_rdata;
    logic            read_req;
    logic            write_req;
    logic            smi_test;
    logic [CH_W-1:0] channel;
    logic            dir;
    logic            cond_tx;

    int n_vec = 0;
    int n_err = 0;
    int pull_cnt = 0;
    int push_cnt = 0;
    logic [31:0] push_last = '0;

    smi_stream_bridge #(
        .SMI_W   (8),
        .WORD_W  (32),
        .NUM_CH  (2),
        .VERSION (8'h02)
    ) dut (
        .i_sys_clk       (clk),
        .i_rst_b         (rst_b),
        .i_ioc           (ioc),
        .i_data_in       (data_in),
        .o_data_out      (data_out),
        .i_cs            (cs),
        .i_fetch_cmd     (fetch),
        .i_load_cmd      (load),
        .o_rx_fifo_pull  (rx_pull),
        .i_rx_fifo_data  (rx_data),
        .i_rx_fifo_empty (rx_empty),
        .o_tx_fifo_push  (tx_push),
        .o_tx_fifo_data  (tx_data),
        .i_tx_fifo_full  (tx_full),
        .i_smi_soe       (soe),
        .i_smi_swe       (swe),
        .i_smi_data      (smi_wdata),
        .o_smi_data      (smi_rdata),
        .o_smi_read_req  (read_req),
        .o_smi_write_req (write_req),
        .i_smi_test      (smi_test),
        .o_channel       (channel),
        .o_dir           (dir),
        .o_cond_tx       (cond_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO-side monitors
    always @(negedge clk) begin
        if (rx_pull) pull_cnt++;
        if (tx_push) begin
            push_cnt++;
            push_last = tx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [7:0] d);
        ioc = a; data_in = d; cs = 1'b1; load = 1'b1;
        tick(1);
        cs = 1'b0; load = 1'b0;
        tick(1);
    endtask

    task automatic reg_rd(input logic [4:0] a, output logic [7:0] d);
        ioc = a; cs = 1'b1; fetch = 1'b1;
        tick(1);
        cs = 1'b0; fetch = 1'b0;
        d = data_out;
        tick(1);
    endtask

    task automatic soe_strobe();
        soe = 1'b0; tick(3);
        soe = 1'b1; tick(3);
    endtask

    task automatic swe_byte(input logic [7:0] b);
        smi_wdata = b;
        swe = 1'b0; tick(3);
        swe = 1'b1; tick(3);
    endtask

    task automatic swe_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        swe_byte(b0); swe_byte(b1); swe_byte(b2); swe_byte(b3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] exp_rx [4];
        logic [7:0] exp_tp [3];
        int p0;
        exp_rx = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_tp = '{8'h56, 8'h57, 8'h58};

        rst_b = 1'b0; ioc = '0; data_in = '0; cs = 1'b0; fetch = 1'b0; load = 1'b0;
        rx_data = '0; rx_empty = 1'b0; tx_full = 1'b1; soe = 1'b1; swe = 1'b1;
        smi_wdata = '0; smi_test = 1'b0;
        tick(3);

        // Reset values, with FIFO flags set to their non-idle levels
        chk("rst_data_out",  data_out,  0);
        chk("rst_read_req",  read_req,  0);
        chk("rst_write_req", write_req, 1);
        chk("rst_pull",      rx_pull,   0);
        chk("rst_push",      tx_push,   0);
        chk("rst_channel",   channel,   0);
        chk("rst_cond_tx",   cond_tx,   0);
        chk("rst_smi_data",  smi_rdata, 0);

        rx_empty = 1'b1; tx_full = 1'b0;
        tick(1);
        rst_b = 1'b1;
        tick(2);
        chk("idle_read_req",  read_req,  0);
        chk("idle_write_req", write_req, 1);
        tx_full = 1'b1; #1;
        chk("full_write_req", write_req, 0);
        tx_full = 1'b0;
        tick(1);

        // Register map
        reg_rd(5'd0, rd); chk("version", rd, 8'h02);
        reg_rd(5'd7, rd); chk("unmapped", rd, 8'h00);
        reg_wr(5'd2, 8'd1); chk("channel_wr1", channel, 1);
        reg_wr(5'd2, 8'd5); chk("channel_wr5_ignored", channel, 1);
        reg_rd(5'd2, rd); chk("channel_rd", rd, 8'h01);
        reg_rd(5'd1, rd); chk("status_idle", rd, 8'h05);

        // RX raw: one word out as four LSB-first slices
        p0 = pull_cnt;
        rx_data = 32'hDDCCBBAA; rx_empty = 1'b0;
        tick(3);
        chk("rx_read_req", read_req, 1);
        rx_empty = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            soe_strobe();
            chk($sformatf("rx_beat%0d", i), smi_rdata, exp_rx[i]);
        end
        tick(2);
        chk("rx_pull_once", pull_cnt - p0, 1);
        chk("rx_read_req_drained", read_req, 0);

        // RX underflow
        for (int i = 0; i < 2; i++) begin
            soe_strobe();
            chk($sformatf("udf_data%0d", i), smi_rdata, 8'h00);
        end
        reg_rd(5'd5, rd); chk("udf_cnt", rd, 8'd2);
        reg_rd(5'd5, rd); chk("udf_cnt_cleared", rd, 8'd0);

        // TX raw
        p0 = push_cnt;
        swe_frame(8'h11, 8'h22, 8'h33, 8'h44);
        tick(2);
        chk("raw_push_cnt", push_cnt - p0, 1);
        chk("raw_push_data", push_last, 32'h44332211);

        // Dir change mid-word restarts the beat count
        p0 = push_cnt;
        swe_byte(8'h77); swe_byte(8'h88);
        reg_wr(5'd3, 8'd1);
        chk("dir_set", dir, 1);
        swe_frame(8'h01, 8'h02, 8'h03, 8'h04);
        tick(2);
        chk("realign_push_cnt", push_cnt - p0, 1);
        chk("realign_push_data", push_last, 32'h04030201);

        // TX framed
        reg_wr(5'd4, 8'd1);
        p0 = push_cnt;
        swe_frame(8'hE5, 8'h12, 8'h34, 8'h56);
        tick(2);
        chk("frm_push_cnt", push_cnt - p0, 1);
        chk("frm_push_data", push_last, 32'h8A4974AC);
        chk("frm_cond_tx", cond_tx, 1);

        // Non-header byte while in SYNC emits the sync word
        p0 = push_cnt;
        swe_byte(8'h05);
        tick(2);
        chk("sync_push_cnt", push_cnt - p0, 1);
        chk("sync_push_data", push_last, 32'h0);

        // Resync, then a complete frame dropped on full
        p0 = push_cnt;
        swe_byte(8'hE5); swe_byte(8'h92);
        tick(2);
        chk("resync_no_push", push_cnt - p0, 0);
        tx_full = 1'b1;
        swe_frame(8'hE5, 8'h12, 8'h34, 8'h56);
        tick(2);
        chk("full_no_push", push_cnt - p0, 0);
        tx_full = 1'b0;
        reg_rd(5'd6, rd); chk("ovf_cnt", rd, 8'd2);
        reg_rd(5'd6, rd); chk("ovf_cnt_cleared", rd, 8'd0);

        // Test pattern: counter bytes, FIFO left alone
        smi_test = 1'b1; rx_empty = 1'b0; #1;
        chk("test_read_req", read_req, 1);
        tick(1);
        p0 = pull_cnt;
        for (int i = 0; i < 3; i++) begin
            soe_strobe();
            chk($sformatf("test_pat%0d", i), smi_rdata, exp_tp[i]);
        end
        tick(2);
        chk("test_no_pull", pull_cnt - p0, 0);
        reg_rd(5'd1, rd); chk("status_test", rd, 8'hE4);
        rx_empty = 1'b1; smi_test = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
